wbp_rx_deframer: RTL and testbench
==================================

# wbp_rx_deframer

Synthesizable pipelined-Wishbone fabric sink that terminates a packet stream (the receiving end of the endpoint/mux fabric links) and converts it into a frame-buffered word stream with valid/ready handshake. Frames are stored in an internal FIFO and released only once complete. Aborted or overflowing frames are rolled back and never appear on the output. It sits behind a fabric source (e.g. a mux output port) and feeds host/NIC-side logic.

## Interface
- g_fifo_log2, 9, log2 of FIFO depth in 16-bit words (depth D = 2^g_fifo_log2)
- clk_sys_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- snk_adr_i  in  2  fabric address: 0 data, 1 OOB, 2 status, 3 user
- snk_dat_i  in  16  fabric data
- snk_sel_i  in  2  byte select; 2'b10 = upper byte only (odd-length last word)
- snk_cyc_i  in  1  frame envelope
- snk_stb_i  in  1  word strobe
- snk_ack_o  out  1  word acknowledge
- snk_err_o  out  1  always 0
- snk_stall_o  out  1  1 during reset, 0 otherwise
- src_dat_o  out  16  output word
- src_valid_o  out  1  output word valid
- src_eop_o  out  1  last word of frame
- src_bytesel_o  out  2  byte validity of src_dat_o
- src_class_o  out  8  frame class, constant for all words of a frame
- src_ready_i  in  1  consumer accepts word when valid&ready
- cnt_frames_o  out  16  committed-frame counter, wraps
- cnt_dropped_o  out  16  dropped-frame counter, wraps

## Operation
- Accepted word: snk_cyc_i & snk_stb_i & !snk_stall_o.
- FIFO entry = {class[7:0], eop, bytesel[1:0], dat[15:0]} (27 bits). Pointers are g_fifo_log2+1 bits; full when wr−rd = D.
- Three pointers: wr_ptr (speculative), commit_ptr (frame boundary), rd_ptr. Output side sees only entries below commit_ptr.
- FSM states IDLE, RECV, DISCARD:
  - IDLE: cyc rise → RECV; class register cleared to 0; wr_ptr = commit_ptr.
  - RECV: adr 2 status word before first data word → class = dat[15:8]. Status word with dat[1]=1 (error) at any point → rollback wr_ptr to commit_ptr, cnt_dropped+1, → DISCARD. adr 0 → write entry with sel as bytesel, eop=0; if FIFO full → rollback, cnt_dropped+1, → DISCARD. adr 1/3 → acked, ignored. cyc fall → if ≥1 data word written: set eop on last written entry, commit_ptr = wr_ptr, cnt_frames+1; else nothing counted; → IDLE.
  - DISCARD: all words acked and ignored; cyc fall → IDLE.
- eop marking: last data entry held in a one-entry staging register, written to FIFO on next data word (eop=0) or on cyc fall (eop=1). Full check counts the staged word.
- Output: first-word-fall-through register; loaded from FIFO when empty or when valid&ready.

## Timing
- Reset: snk_ack_o=0, snk_stall_o=1, src_valid_o=0, src_eop_o=0, src_dat_o=0, src_bytesel_o=0, src_class_o=0, counters 0, all pointers 0, FSM IDLE. Reset mid-frame discards all FIFO content including committed frames.
- snk_ack_o: registered, high exactly one cycle after each accepted word, in every state.
- Commit: cyc low sampled at edge k → commit_ptr/counter updated at edge k+1 (staging flush), src_valid_o high after edge k+2 if output register empty.
- Output throughput 1 word/cycle while src_ready_i=1; src_valid_o drops for no cycles inside a committed frame.
- Back-to-back frames: cyc may reassert the cycle after falling; staging flush and new frame start coexist.
- Simultaneous error status and cyc fall on same edge: status processed first → frame dropped.
- Read and write on same edge at full: write sees occupancy before read (conservative → drop).

## Test plan
- Frame: status 0x0300, 5 data words 0x0001..0x0005, last sel 2'b10 → 5 output words, class 0x03, eop only on word 5 with bytesel 2'b10, cnt_frames=1.
- Error abort: status 0x0100, 3 data words, status 0x0002 → no output, cnt_dropped=1; following good 2-word frame emerges alone with class as sent.
- Overflow, g_fifo_log2=4: 20-word frame → dropped, cnt_dropped=1, FIFO empty; then 16-word frame → accepted in full, eop on 16th.
- Backpressure: src_ready_i toggled 1/0 every cycle over three 10-word frames → 30 words in order, no loss/duplication, snk_stall_o stays 0.
- Empty frame: cyc high 4 cycles, only status + OOB words → each acked 1 cycle later, no output, counters unchanged.
- Reset mid-frame after 2 committed frames and partial third → all outputs at reset values next cycle, no stale words after release.

Source files
------------

// File: rtl/wbp_rx_deframer.sv
// wbp_rx_deframer
//   Pipelined-Wishbone fabric sink. Incoming frames are buffered in a FIFO
//   and released on a valid/ready stream only once they are complete.
//   Frames that are aborted (error status) or that overflow the FIFO are
//   rolled back and never reach the output.
// Ports:
//   clk_sys_i, rst_i           clock, synchronous active-high reset
//   snk_*                      fabric sink (adr 0 data, 1 OOB, 2 status, 3 user)
//   src_dat_o/valid/eop/bytesel/class, src_ready_i   frame-buffered output stream
//   cnt_frames_o, cnt_dropped_o  committed / dropped frame counters (wrapping)
module wbp_rx_deframer #(
  parameter int unsigned g_fifo_log2 = 9
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_sel_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  output logic        snk_ack_o,
  output logic        snk_err_o,
  output logic        snk_stall_o,
  output logic [15:0] src_dat_o,
  output logic        src_valid_o,
  output logic        src_eop_o,
  output logic [1:0]  src_bytesel_o,
  output logic [7:0]  src_class_o,
  input  logic        src_ready_i,
  output logic [15:0] cnt_frames_o,
  output logic [15:0] cnt_dropped_o
);

  localparam int unsigned D = 1 << g_fifo_log2;
  localparam int unsigned P = g_fifo_log2 + 1;
  localparam logic [P-1:0] PTR_ONE = P'(1);
  localparam logic [P:0]   DEPTH   = (P+1)'(D);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;

  state_t state, state_nxt;

  logic         stall_r, ack_r;
  logic [P-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic         stg_valid, flush_pend;
  logic [15:0]  stg_dat;
  logic [1:0]   stg_sel;
  logic [7:0]   stg_class, class_r;
  logic [15:0]  cnt_frames, cnt_dropped;

  logic [26:0]  mem [D];

  logic         acc, start, active, is_data, is_stat, err, ovf, drop, data_ok;
  logic         fifo_we, frame_end, rd_avail, load;
  logic [P:0]   occ;
  logic [P-1:0] commit_nxt;
  logic [7:0]   class_cur;
  logic [26:0]  rd_word;

  always_comb begin
    acc        = snk_cyc_i & snk_stb_i & ~stall_r;
    start      = (state == S_IDLE) & snk_cyc_i;
    active     = start | (state == S_RECV);
    is_data    = acc & (snk_adr_i == 2'd0);
    is_stat    = acc & (snk_adr_i == 2'd2);
    err        = active & is_stat & snk_dat_i[1];
    // Occupancy uses the registered read pointer and includes the staged
    // word, so a word is only taken if both it and the staged one will fit.
    occ        = {1'b0, wr_ptr - rd_ptr} + {{P{1'b0}}, stg_valid};
    ovf        = active & is_data & (occ >= DEPTH);
    drop       = err | ovf;
    data_ok    = active & is_data & ~drop;
    // A pending flush and the first data word of the next frame can share
    // an edge: the old staged word goes to the FIFO with eop set while the
    // new word takes its place in staging.
    fifo_we    = stg_valid & (flush_pend | data_ok);
    commit_nxt = flush_pend ? (wr_ptr + PTR_ONE) : commit_ptr;
    frame_end  = (state == S_RECV) & ~snk_cyc_i;
    class_cur  = start ? '0 : class_r;
    rd_avail   = (rd_ptr != commit_ptr);
    load       = rd_avail & (~src_valid_o | src_ready_i);
    rd_word    = mem[rd_ptr[g_fifo_log2-1:0]];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (snk_cyc_i) state_nxt = drop ? S_DISCARD : S_RECV;
      S_RECV:    if (!snk_cyc_i) state_nxt = S_IDLE;
                 else if (drop) state_nxt = S_DISCARD;
      S_DISCARD: if (!snk_cyc_i) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (fifo_we) mem[wr_ptr[g_fifo_log2-1:0]] <= {stg_class, flush_pend, stg_sel, stg_dat};
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      stall_r       <= 1'b1;
      ack_r         <= 1'b0;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      stg_valid     <= 1'b0;
      flush_pend    <= 1'b0;
      stg_dat       <= '0;
      stg_sel       <= '0;
      stg_class     <= '0;
      class_r       <= '0;
      cnt_frames    <= '0;
      cnt_dropped   <= '0;
      src_dat_o     <= '0;
      src_valid_o   <= 1'b0;
      src_eop_o     <= 1'b0;
      src_bytesel_o <= '0;
      src_class_o   <= '0;
    end else begin
      state      <= state_nxt;
      stall_r    <= 1'b0;
      ack_r      <= acc;
      flush_pend <= frame_end & stg_valid;

      if (start)
        class_r <= is_stat ? snk_dat_i[15:8] : '0;
      else if ((state == S_RECV) && is_stat && !stg_valid)
        class_r <= snk_dat_i[15:8];

      if (flush_pend) begin
        commit_ptr <= commit_nxt;
        cnt_frames <= cnt_frames + 16'd1;
      end

      if (drop) begin
        wr_ptr      <= commit_nxt;
        cnt_dropped <= cnt_dropped + 16'd1;
      end else if (fifo_we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (drop)         stg_valid <= 1'b0;
      else if (data_ok) stg_valid <= 1'b1;
      else if (fifo_we) stg_valid <= 1'b0;

      if (data_ok) begin
        stg_dat   <= snk_dat_i;
        stg_sel   <= snk_sel_i;
        stg_class <= class_cur;
      end

      if (load) begin
        {src_class_o, src_eop_o, src_bytesel_o, src_dat_o} <= rd_word;
        src_valid_o <= 1'b1;
        rd_ptr      <= rd_ptr + PTR_ONE;
      end else if (src_valid_o && src_ready_i) begin
        src_valid_o <= 1'b0;
      end
    end
  end

  assign snk_ack_o     = ack_r;
  assign snk_stall_o   = stall_r;
  assign snk_err_o     = 1'b0;
  assign cnt_frames_o  = cnt_frames;
  assign cnt_dropped_o = cnt_dropped;

endmodule

// File: tb/tb_wbp_rx_deframer.sv
// Directed testbench for wbp_rx_deframer (FIFO depth 16 words).
module tb_wbp_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  adr;
  logic [15:0] dat;
  logic [1:0]  sel;
  logic        cyc, stb, ack, err, stall;
  logic [15:0] src_dat;
  logic        src_valid, src_eop;
  logic [1:0]  src_bytesel;
  logic [7:0]  src_class;
  logic        ready;
  logic [15:0] cnt_frames, cnt_dropped;

  wbp_rx_deframer #(.g_fifo_log2(4)) dut (
    .clk_sys_i(clk), .rst_i(rst),
    .snk_adr_i(adr), .snk_dat_i(dat), .snk_sel_i(sel),
    .snk_cyc_i(cyc), .snk_stb_i(stb), .snk_ack_o(ack),
    .snk_err_o(err), .snk_stall_o(stall),
    .src_dat_o(src_dat), .src_valid_o(src_valid), .src_eop_o(src_eop),
    .src_bytesel_o(src_bytesel), .src_class_o(src_class), .src_ready_i(ready),
    .cnt_frames_o(cnt_frames), .cnt_dropped_o(cnt_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } wb_word_t;

  wb_word_t    txq[$];
  logic [26:0] rx_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  rmode = 2'd0;   // 0 ready high, 1 toggle, 2 ready low
  logic        bp_active = 1'b0;
  logic        stall_bad = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] ent(input logic [7:0] c, input logic e,
                                      input logic [1:0] s, input logic [15:0] d);
    return {c, e, s, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
    wb_word_t w;
    w.adr = a; w.dat = d; w.sel = s;
    txq.push_back(w);
  endtask

  task automatic build_frame(input logic [7:0] c, input int n, input logic [15:0] base,
                             input logic [1:0] last_sel);
    push(2'd2, {c, 8'h00}, 2'b11);
    for (int i = 0; i < n; i++)
      push(2'd0, base + 16'(i), (i == n - 1) ? last_sel : 2'b11);
  endtask

  // Streams txq one word per cycle; every word must be acked the cycle after.
  task automatic send_frame(input bit drop_cyc);
    foreach (txq[i]) begin
      cyc = 1'b1; stb = 1'b1;
      adr = txq[i].adr; dat = txq[i].dat; sel = txq[i].sel;
      tick();
      check_val("ack", {31'd0, ack}, 32'd1);
    end
    stb = 1'b0;
    if (drop_cyc) begin
      cyc = 1'b0;
      tick();
      check_val("ack_idle", {31'd0, ack}, 32'd0);
    end
    txq.delete();
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 && rx_q.size() < n; i++) tick();
    check_val("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [26:0] exp);
    logic [26:0] got;
    got = (idx < rx_q.size()) ? rx_q[idx] : 'x;
    check_val(tag, {5'd0, got}, {5'd0, exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    check_val({tag, "_ack"},   {31'd0, ack}, 32'd0);
    check_val({tag, "_stall"}, {31'd0, stall}, 32'd1);
    check_val({tag, "_out"},   {5'd0, src_valid, src_eop, src_bytesel, src_class, src_dat}, 32'd0);
    check_val({tag, "_cnt"},   {cnt_frames, cnt_dropped}, 32'd0);
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        2'd0:    ready = 1'b1;
        2'd1:    ready = ~ready;
        default: ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (src_valid && ready)
        rx_q.push_back({src_class, src_eop, src_bytesel, src_dat});
      if (bp_active && stall) stall_bad = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; adr = '0; dat = '0; sel = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    check_val("err_o", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();
    check_val("stall_run", {31'd0, stall}, 32'd0);

    // Basic frame with odd-length last word
    build_frame(8'h03, 5, 16'h0001, 2'b10);
    send_frame(1'b1);
    wait_rx(5);
    for (int i = 0; i < 4; i++)
      chk_word("f1_word", i, ent(8'h03, 1'b0, 2'b11, 16'(i + 1)));
    chk_word("f1_last", 4, ent(8'h03, 1'b1, 2'b10, 16'h0005));
    repeat (5) tick();
    check_val("f1_no_extra", 32'(rx_q.size()), 32'd5);
    check_val("f1_cnt", {cnt_frames, cnt_dropped}, {16'd1, 16'd0});
    rx_q.delete();

    // Error abort followed back-to-back by a good frame
    push(2'd2, 16'h0100, 2'b11);
    push(2'd0, 16'hA0A0, 2'b11);
    push(2'd0, 16'hB0B0, 2'b11);
    push(2'd0, 16'hC0C0, 2'b11);
    push(2'd2, 16'h0002, 2'b11);
    send_frame(1'b1);
    build_frame(8'h07, 2, 16'h1111, 2'b11);
    txq[2].dat = 16'h2222;
    send_frame(1'b1);
    wait_rx(2);
    chk_word("abort_w0", 0, ent(8'h07, 1'b0, 2'b11, 16'h1111));
    chk_word("abort_w1", 1, ent(8'h07, 1'b1, 2'b11, 16'h2222));
    repeat (5) tick();
    check_val("abort_no_extra", 32'(rx_q.size()), 32'd2);
    check_val("abort_cnt", {cnt_frames, cnt_dropped}, {16'd2, 16'd1});
    rx_q.delete();

    // Overflow: 20 words dropped, then exactly-full 16-word frame
    build_frame(8'h05, 20, 16'h0100, 2'b11);
    send_frame(1'b1);
    repeat (10) tick();
    check_val("ovf_empty", 32'(rx_q.size()), 32'd0);
    check_val("ovf_cnt", {cnt_frames, cnt_dropped}, {16'd2, 16'd2});
    build_frame(8'h06, 16, 16'h0200, 2'b11);
    send_frame(1'b1);
    wait_rx(16);
    for (int i = 0; i < 16; i++)
      chk_word("full_word", i, ent(8'h06, (i == 15), 2'b11, 16'h0200 + 16'(i)));
    check_val("full_cnt", {cnt_frames, cnt_dropped}, {16'd3, 16'd2});
    rx_q.delete();

    // Backpressure: ready toggling over three 10-word frames
    rmode = 2'd1; bp_active = 1'b1;
    for (int f = 0; f < 3; f++) begin
      build_frame(8'h0A + 8'(f), 10, 16'h3000 + 16'(f * 16), 2'b11);
      send_frame(1'b1);
      wait_rx(10 * (f + 1));
    end
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 10; i++)
        chk_word("bp_word", f * 10 + i,
                 ent(8'h0A + 8'(f), (i == 9), 2'b11, 16'h3000 + 16'(f * 16 + i)));
    repeat (6) tick();
    check_val("bp_no_extra", 32'(rx_q.size()), 32'd30);
    bp_active = 1'b0;
    check_val("bp_stall", {31'd0, stall_bad}, 32'd0);
    check_val("bp_cnt", {cnt_frames, cnt_dropped}, {16'd6, 16'd2});
    rmode = 2'd0;
    rx_q.delete();

    // Empty frame: status and OOB words only
    push(2'd2, 16'h0400, 2'b11);
    push(2'd1, 16'hAAAA, 2'b11);
    push(2'd3, 16'hBBBB, 2'b11);
    push(2'd1, 16'hCCCC, 2'b11);
    send_frame(1'b1);
    repeat (8) tick();
    check_val("empty_rx", 32'(rx_q.size()), 32'd0);
    check_val("empty_cnt", {cnt_frames, cnt_dropped}, {16'd6, 16'd2});

    // Reset mid-frame with committed frames still buffered
    rmode = 2'd2;
    repeat (2) tick();
    build_frame(8'h11, 3, 16'h4000, 2'b11);
    send_frame(1'b1);
    build_frame(8'h22, 3, 16'h5000, 2'b11);
    send_frame(1'b1);
    repeat (6) tick();
    check_val("pre_rst_cnt", {15'd0, src_valid, cnt_frames}, {15'd0, 1'b1, 16'd8});
    build_frame(8'h33, 2, 16'h6000, 2'b11);
    send_frame(1'b0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    cyc = 1'b0;
    tick();
    rst = 1'b0;
    rmode = 2'd0;
    repeat (20) tick();
    check_val("post_rst_rx", 32'(rx_q.size()), 32'd0);
    check_val("post_rst_state", {15'd0, src_valid, cnt_frames | cnt_dropped}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
